// File: rtl/axi_defines.sv
// Shared AXI4-Lite response codes and FSM state encodings for the dual-path slave.
package axi_defines;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_USER = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_USER = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi_lite_user_timer.sv
// User-ack watchdog: expire is high in the TIMEOUT_CYCLES-th cycle after start; 0 disables it.
// Count saturates at TIMEOUT_CYCLES-1 and never wraps; clear wins over start.
module axi_lite_user_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_timer;
      assign unused_timer = ^{clk, rst, start, clear};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic          running;
      logic [CW-1:0] count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          running <= 1'b0;
          count   <= '0;
        end else if (clear) begin
          running <= 1'b0;
          count   <= '0;
        end else if (start) begin
          running <= 1'b1;
          count   <= '0;
        end else if (running && count != LAST) begin
          count <= count + 1'b1;
        end
      end

      assign expire = running && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/axi_lite_slave_dual.sv
// AXI4-Lite slave with independent write/read paths to a user register port; 2-cycle min latency.
// Responses hold until bready/rready; channel readies stay low while a path is busy.
module axi_lite_slave_dual
  import axi_defines::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [STROBE_WIDTH-1:0] i_wstrb,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [1:0]              o_bresp,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_wr_req,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [STROBE_WIDTH-1:0] o_wr_strb,
  input  logic                    i_wr_ack,
  input  logic                    i_wr_err,
  output logic                    o_rd_req,
  output logic [ADDR_WIDTH-1:0]   o_rd_addr,
  input  logic                    i_rd_ack,
  input  logic [DATA_WIDTH-1:0]   i_rd_data,
  input  logic                    i_rd_err
);

  w_state_t w_state;
  r_state_t r_state;
  logic     aw_have, w_have;
  logic     aw_hs, w_hs, w_go, ar_hs;
  logic     wr_expire, rd_expire;
  logic     wr_tmr_clear, rd_tmr_clear;

  assign aw_hs = (w_state == W_IDLE) && i_awvalid && o_awready;
  assign w_hs  = (w_state == W_IDLE) && i_wvalid && o_wready;
  // Either beat may arrive first; the request fires once both are held.
  assign w_go  = (w_state == W_IDLE) && (aw_have || aw_hs) && (w_have || w_hs);
  assign ar_hs = (r_state == R_IDLE) && i_arvalid && o_arready;

  assign wr_tmr_clear = (w_state == W_USER) && (i_wr_ack || wr_expire);
  assign rd_tmr_clear = (r_state == R_USER) && (i_rd_ack || rd_expire);

  axi_lite_user_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
    .clk(clk), .rst(rst), .start(w_go), .clear(wr_tmr_clear), .expire(wr_expire)
  );

  axi_lite_user_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
    .clk(clk), .rst(rst), .start(ar_hs), .clear(rd_tmr_clear), .expire(rd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      o_awready <= 1'b0;
      o_wready  <= 1'b0;
      o_wr_req  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_wr_strb <= '0;
      o_bvalid  <= 1'b0;
      o_bresp   <= AXI_RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            o_wr_addr <= i_awaddr;
            aw_have   <= 1'b1;
            o_awready <= 1'b0;
          end else if (!aw_have) begin
            o_awready <= 1'b1;
          end
          if (w_hs) begin
            o_wr_data <= i_wdata;
            o_wr_strb <= i_wstrb;
            w_have    <= 1'b1;
            o_wready  <= 1'b0;
          end else if (!w_have) begin
            o_wready <= 1'b1;
          end
          if (w_go) begin
            aw_have  <= 1'b0;
            w_have   <= 1'b0;
            o_wr_req <= 1'b1;
            w_state  <= W_USER;
          end
        end
        W_USER: begin
          if (i_wr_ack) begin
            o_wr_req <= 1'b0;
            o_bvalid <= 1'b1;
            o_bresp  <= i_wr_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            w_state  <= W_RESP;
          end else if (wr_expire) begin
            o_wr_req <= 1'b0;
            o_bvalid <= 1'b1;
            o_bresp  <= AXI_RESP_SLVERR;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            o_bvalid  <= 1'b0;
            o_bresp   <= AXI_RESP_OKAY;
            o_awready <= 1'b1;
            o_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: begin
          aw_have   <= 1'b0;
          w_have    <= 1'b0;
          o_awready <= 1'b0;
          o_wready  <= 1'b0;
          o_wr_req  <= 1'b0;
          o_bvalid  <= 1'b0;
          o_bresp   <= AXI_RESP_OKAY;
          w_state   <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      o_arready <= 1'b0;
      o_rd_req  <= 1'b0;
      o_rd_addr <= '0;
      o_rvalid  <= 1'b0;
      o_rdata   <= '0;
      o_rresp   <= AXI_RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            o_arready <= 1'b0;
            o_rd_req  <= 1'b1;
            o_rd_addr <= i_araddr;
            r_state   <= R_USER;
          end else begin
            o_arready <= 1'b1;
          end
        end
        R_USER: begin
          if (i_rd_ack) begin
            o_rd_req <= 1'b0;
            o_rvalid <= 1'b1;
            o_rdata  <= i_rd_data;
            o_rresp  <= i_rd_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            r_state  <= R_RESP;
          end else if (rd_expire) begin
            o_rd_req <= 1'b0;
            o_rvalid <= 1'b1;
            o_rdata  <= '0;
            o_rresp  <= AXI_RESP_SLVERR;
            r_state  <= R_RESP;
          end
        end
        R_RESP: begin
          if (i_rready) begin
            o_rvalid  <= 1'b0;
            o_rresp   <= AXI_RESP_OKAY;
            o_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: begin
          o_arready <= 1'b0;
          o_rd_req  <= 1'b0;
          o_rvalid  <= 1'b0;
          o_rresp   <= AXI_RESP_OKAY;
          r_state   <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_dual.sv
// Directed bench for axi_lite_slave_dual with an 8-cycle user timeout.
module tb_axi_lite_slave_dual;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic        i_arvalid = 1'b0, i_rready = 1'b0;
  logic [31:0] i_awaddr = '0, i_wdata = '0, i_araddr = '0, i_rd_data = '0;
  logic [3:0]  i_wstrb = '0;
  logic        i_wr_ack = 1'b0, i_wr_err = 1'b0, i_rd_ack = 1'b0, i_rd_err = 1'b0;
  logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_wr_req, o_rd_req;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata, o_wr_addr, o_wr_data, o_rd_addr;
  logic [3:0]  o_wr_strb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_slave_dual #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_strb(o_wr_strb),
    .i_wr_ack(i_wr_ack), .i_wr_err(i_wr_err),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .i_rd_ack(i_rd_ack), .i_rd_data(i_rd_data), .i_rd_err(i_rd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid, o_rdata, o_rresp,
                   o_wr_req, o_wr_addr, o_wr_data, o_wr_strb, o_rd_req, o_rd_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero during reset"); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({o_awready, o_wready, o_arready} !== 3'b111) begin
      errors++; $display("FAIL reset_readies got=%b exp=111", {o_awready, o_wready, o_arready}); end
    // Stray acks with nothing pending must not produce responses.
    i_wr_ack = 1'b1; i_rd_ack = 1'b1;
    tick();
    i_wr_ack = 1'b0; i_rd_ack = 1'b0;
    tick();
    checks++; if ({o_bvalid, o_rvalid, o_wr_req, o_rd_req} !== 4'b0000) begin
      errors++; $display("FAIL stray_ack got=%b exp=0000", {o_bvalid, o_rvalid, o_wr_req, o_rd_req}); end
  endtask

  task automatic test_w_before_aw();
    i_wvalid = 1'b1; i_wdata = 32'hDEADBEEF; i_wstrb = 4'b0101;
    tick();
    i_wvalid = 1'b0; i_wdata = '0; i_wstrb = '0;
    checks++; if ({o_wready, o_awready, o_wr_req} !== 3'b010) begin
      errors++; $display("FAIL wfirst_ready got=%b exp=010", {o_wready, o_awready, o_wr_req}); end
    tick();
    tick();
    i_awvalid = 1'b1; i_awaddr = 32'h10;
    tick();
    i_awvalid = 1'b0; i_awaddr = '0;
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL wfirst_req got=%b exp=1", o_wr_req); end
    checks++; if (o_wr_addr !== 32'h10) begin errors++; $display("FAIL wfirst_addr got=%h exp=10", o_wr_addr); end
    checks++; if (o_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wfirst_data got=%h exp=deadbeef", o_wr_data); end
    checks++; if (o_wr_strb !== 4'b0101) begin errors++; $display("FAIL wfirst_strb got=%b exp=0101", o_wr_strb); end
    checks++; if ({o_awready, o_wready} !== 2'b00) begin errors++; $display("FAIL wfirst_busy got=%b exp=00", {o_awready, o_wready}); end
    i_wr_ack = 1'b1;
    tick();
    i_wr_ack = 1'b0;
    checks++; if ({o_wr_req, o_bvalid, o_bresp} !== 4'b0100) begin
      errors++; $display("FAIL wfirst_bresp got=%b exp=0100", {o_wr_req, o_bvalid, o_bresp}); end
    i_bready = 1'b1;
    tick();
    i_bready = 1'b0;
    checks++; if ({o_bvalid, o_awready, o_wready} !== 3'b011) begin
      errors++; $display("FAIL wfirst_done got=%b exp=011", {o_bvalid, o_awready, o_wready}); end
  endtask

  task automatic test_concurrent();
    i_awvalid = 1'b1; i_awaddr = 32'h20; i_wvalid = 1'b1; i_wdata = 32'hA5A5A5A5; i_wstrb = 4'hF;
    i_arvalid = 1'b1; i_araddr = 32'h24;
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    checks++; if ({o_wr_req, o_rd_req, o_arready} !== 3'b110) begin
      errors++; $display("FAIL conc_req got=%b exp=110", {o_wr_req, o_rd_req, o_arready}); end
    checks++; if (o_rd_addr !== 32'h24) begin errors++; $display("FAIL conc_rdaddr got=%h exp=24", o_rd_addr); end
    checks++; if (o_wr_addr !== 32'h20) begin errors++; $display("FAIL conc_wraddr got=%h exp=20", o_wr_addr); end
    i_rd_ack = 1'b1; i_rd_data = 32'h1234;
    tick();
    i_rd_ack = 1'b0; i_rd_data = '0;
    checks++; if ({o_rvalid, o_rresp} !== 3'b100 || o_rdata !== 32'h1234) begin
      errors++; $display("FAIL conc_rdata got=%b/%h exp=100/1234", {o_rvalid, o_rresp}, o_rdata); end
    checks++; if ({o_wr_req, o_bvalid} !== 2'b10) begin
      errors++; $display("FAIL conc_wpending got=%b exp=10", {o_wr_req, o_bvalid}); end
    i_rready = 1'b1;
    tick();
    i_rready = 1'b0;
    checks++; if ({o_rvalid, o_arready, o_wr_req} !== 3'b011) begin
      errors++; $display("FAIL conc_rdone got=%b exp=011", {o_rvalid, o_arready, o_wr_req}); end
    i_wr_ack = 1'b1;
    tick();
    i_wr_ack = 1'b0;
    checks++; if ({o_bvalid, o_bresp} !== 3'b100) begin
      errors++; $display("FAIL conc_bresp got=%b exp=100", {o_bvalid, o_bresp}); end
    i_bready = 1'b1;
    tick();
    i_bready = 1'b0;
    checks++; if (o_bvalid !== 1'b0) begin errors++; $display("FAIL conc_bdone got=%b exp=0", o_bvalid); end
  endtask

  task automatic test_errors();
    i_arvalid = 1'b1; i_araddr = 32'h30;
    tick();
    i_arvalid = 1'b0;
    i_rd_ack = 1'b1; i_rd_err = 1'b1; i_rd_data = 32'h0000FFFF;
    tick();
    i_rd_ack = 1'b0; i_rd_err = 1'b0; i_rd_data = '0;
    checks++; if ({o_rvalid, o_rresp} !== 3'b111) begin
      errors++; $display("FAIL err_rresp got=%b exp=111", {o_rvalid, o_rresp}); end
    i_rready = 1'b1;
    tick();
    i_rready = 1'b0;
    i_awvalid = 1'b1; i_awaddr = 32'h34; i_wvalid = 1'b1; i_wdata = 32'h1; i_wstrb = 4'h1;
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    i_wr_ack = 1'b1; i_wr_err = 1'b1;
    tick();
    i_wr_ack = 1'b0; i_wr_err = 1'b0;
    checks++; if ({o_bvalid, o_bresp} !== 3'b111) begin
      errors++; $display("FAIL err_bresp got=%b exp=111", {o_bvalid, o_bresp}); end
    i_bready = 1'b1;
    tick();
    i_bready = 1'b0;
  endtask

  task automatic test_timeout();
    i_arvalid = 1'b1; i_araddr = 32'h40; i_rd_data = 32'hCAFE;
    tick();
    i_arvalid = 1'b0;
    repeat (7) tick();
    checks++; if (o_rd_req !== 1'b1) begin errors++; $display("FAIL to_rd_held got=%b exp=1", o_rd_req); end
    tick();
    checks++; if ({o_rd_req, o_rvalid, o_rresp} !== 4'b0110) begin
      errors++; $display("FAIL to_rd_resp got=%b exp=0110", {o_rd_req, o_rvalid, o_rresp}); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL to_rd_data got=%h exp=0", o_rdata); end
    i_rd_data = '0; i_rready = 1'b1;
    tick();
    i_rready = 1'b0;

    i_awvalid = 1'b1; i_wvalid = 1'b1; i_awaddr = 32'h44;
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    repeat (7) tick();
    checks++; if ({o_wr_req, o_bvalid} !== 2'b10) begin
      errors++; $display("FAIL to_wr_held got=%b exp=10", {o_wr_req, o_bvalid}); end
    i_wr_ack = 1'b1;
    tick();
    i_wr_ack = 1'b0;
    checks++; if ({o_wr_req, o_bvalid, o_bresp} !== 4'b0100) begin
      errors++; $display("FAIL to_ackwins got=%b exp=0100", {o_wr_req, o_bvalid, o_bresp}); end
    i_bready = 1'b1;
    tick();
    i_bready = 1'b0;

    i_awvalid = 1'b1; i_wvalid = 1'b1;
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    repeat (8) tick();
    checks++; if ({o_wr_req, o_bvalid, o_bresp} !== 4'b0110) begin
      errors++; $display("FAIL to_wr_resp got=%b exp=0110", {o_wr_req, o_bvalid, o_bresp}); end
    i_bready = 1'b1;
    tick();
    i_bready = 1'b0;
  endtask

  task automatic test_backpressure();
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_awaddr = 32'h50; i_arvalid = 1'b1; i_araddr = 32'h54;
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    i_wr_ack = 1'b1; i_rd_ack = 1'b1; i_rd_data = 32'h5A5A;
    tick();
    i_wr_ack = 1'b0; i_rd_ack = 1'b0; i_rd_data = '0;
    // Keep valids asserted so a premature ready would be visible as a handshake.
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({o_bvalid, o_bresp, o_rvalid, o_rresp} !== 6'b100100 || o_rdata !== 32'h5A5A) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b/%h exp=100100/5a5a", i, {o_bvalid, o_bresp, o_rvalid, o_rresp}, o_rdata); end
      checks++; if ({o_awready, o_wready, o_arready} !== 3'b000) begin
        errors++; $display("FAIL bp_ready[%0d] got=%b exp=000", i, {o_awready, o_wready, o_arready}); end
    end
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    i_bready = 1'b1; i_rready = 1'b1;
    tick();
    i_bready = 1'b0; i_rready = 1'b0;
    checks++; if ({o_bvalid, o_rvalid, o_awready, o_wready, o_arready} !== 5'b00111) begin
      errors++; $display("FAIL bp_release got=%b exp=00111", {o_bvalid, o_rvalid, o_awready, o_wready, o_arready}); end
  endtask

  task automatic test_reset_mid();
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_awaddr = 32'h60; i_wdata = 32'h77; i_wstrb = 4'hF;
    i_arvalid = 1'b1; i_araddr = 32'h64;
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    i_rd_ack = 1'b1; i_rd_data = 32'h99;
    tick();
    i_rd_ack = 1'b0; i_rd_data = '0;
    checks++; if ({o_wr_req, o_rvalid} !== 2'b11) begin
      errors++; $display("FAIL rstmid_setup got=%b exp=11", {o_wr_req, o_rvalid}); end
    rst = 1'b1;
    #1;
    checks++; if ({o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid, o_rdata, o_rresp,
                   o_wr_req, o_wr_addr, o_wr_data, o_wr_strb, o_rd_req, o_rd_addr} !== '0) begin
      errors++; $display("FAIL rstmid_async: some output nonzero right after reset asserted"); end
    tick();
    rst = 1'b0;
    i_wr_ack = 1'b1; i_rd_ack = 1'b1; i_bready = 1'b1; i_rready = 1'b1;
    tick();
    i_wr_ack = 1'b0; i_rd_ack = 1'b0; i_bready = 1'b0; i_rready = 1'b0;
    checks++; if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_wr_req, o_rd_req} !== 7'b1110000) begin
      errors++; $display("FAIL rstmid_release got=%b exp=1110000", {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_wr_req, o_rd_req}); end
    repeat (3) tick();
    checks++; if ({o_bvalid, o_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rstmid_noresp got=%b exp=00", {o_bvalid, o_rvalid}); end
  endtask

  initial begin
    test_reset();
    test_w_before_aw();
    test_concurrent();
    test_errors();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
